// File: rtl/fifo_drain_reader.sv
// Consumer-side FIFO reader: paces read strobes against the lagging empty/ale
// flags and forwards captured words through a 3-entry skid buffer.
module fifo_drain_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  empty,
  input  logic                  ale,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  read,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [1:0]            dbg_state,
  output logic [1:0]            dbg_occ
);

  // Stream handshake: m_valid/m_data are held stable until an edge where
  // m_valid and m_ready are both 1; that edge is the one and only transfer.

  typedef enum logic [1:0] {IDLE, BURST, SINGLE, GAP} state_t;

  state_t                state;
  state_t                state_next;
  logic                  read_next;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] mem [0:2];
  logic [1:0]            head;
  logic [1:0]            tail;
  logic [1:0]            occ;
  logic [1:0]            occ_next;
  logic                  push;
  logic                  pop;
  logic                  space;
  logic                  go;

  // A word lands one edge after read was sampled, so inflight is the push.
  assign push     = inflight;
  assign pop      = m_valid & m_ready;
  assign occ_next = occ + {1'b0, push} - {1'b0, pop};
  // Count the word already on its way from the current strobe as well.
  assign space    = ({1'b0, occ_next} + {2'b00, read}) <= 3'd2;
  assign go       = enable & ~empty & space;

  assign m_valid   = (occ != 2'd0);
  assign m_data    = mem[head];
  assign dbg_state = state;
  assign dbg_occ   = occ;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (go) state_next = ale ? SINGLE : BURST;
      end
      BURST: begin
        if (!(go && !ale)) state_next = GAP;
      end
      SINGLE:  state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    read_next = (state_next == BURST) || (state_next == SINGLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      read     <= 1'b0;
      inflight <= 1'b0;
    end else begin
      state    <= state_next;
      read     <= read_next;
      inflight <= read;
    end
  end

  // Full buffer with simultaneous push and pop: the head slot is overwritten
  // exactly as it is consumed, so nothing is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      mem[2]   <= '0;
      head     <= 2'd0;
      tail     <= 2'd0;
      occ      <= 2'd0;
      rd_count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= dout;
        tail      <= (tail == 2'd2) ? 2'd0 : tail + 2'd1;
      end
      if (pop) begin
        head     <= (head == 2'd2) ? 2'd0 : head + 2'd1;
        rd_count <= rd_count + 1'b1;
      end
      occ <= occ_next;
    end
  end

endmodule

// File: doc/fifo_drain_reader.md
# fifo_drain_reader

Read-side controller that sits on the consumer end of the FIFO bus. It watches the FIFO's `empty`/`ale` status, issues `read` strobes, captures `dout` one cycle later, and presents the words downstream on a valid/ready stream through a 3-entry skid buffer. Its FSM paces reads so the FIFO is never read while empty, even though the status flags it samples lag each pop by one cycle.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: FIFO word width, matching the FIFO's `din`/`dout`.
- `CNT_WIDTH`, default 16: width of the delivered-word counter.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: asynchronous, active-low reset. Assertion is asynchronous.
- `enable`  in  1: when 1, new FIFO reads may be issued. When 0, no new reads start; an in-flight word still lands.
- `empty`  in  1: FIFO empty flag.
- `ale`  in  1: FIFO almost-empty flag. The FIFO's almost-empty threshold is at least 2 entries.
- `dout`  in  DATA_WIDTH: FIFO read data. It is valid at the edge after the edge where `read` was sampled high.
- `read`  out  1: FIFO read strobe. Registered.
- `m_data`  out  DATA_WIDTH: downstream data, equal to the head of the skid buffer.
- `m_valid`  out  1: skid buffer is non-empty.
- `m_ready`  in  1: downstream accept. A transfer happens at an edge where `m_valid` and `m_ready` are both 1.
- `rd_count`  out  CNT_WIDTH: number of words delivered downstream.

## Operation
- **Skid buffer:** 3-entry circular buffer with occupancy `occ` (0..3).
  - A landing word is pushed at the edge after the edge where `read` was sampled high.
  - A downstream transfer pops the head.
  - A push and a pop at the same edge leave `occ` unchanged.
- **Space rule:** a read may be asserted for the next cycle only if `occ_next + read ≤ 2`.
  - `occ_next` is the post-edge occupancy.
  - `read` is the current strobe, whose word lands next edge.
  - This guarantees the buffer never overflows.
- **Read permission:** `go = enable & ~empty & space`.
- **FSM states:** IDLE, BURST, SINGLE, GAP.
  - **IDLE** (`read=0`): if `go & ~ale`, go to BURST. If `go & ale`, go to SINGLE. Otherwise stay.
  - **BURST** (`read=1`): stay while `go & ~ale`. Otherwise go to GAP.
    - Back-to-back reads are safe here because at least 2 entries remain.
  - **SINGLE** (`read=1` for exactly one cycle): always go to GAP.
  - **GAP** (`read=0`): one settle cycle so `empty`/`ale` reflect the last pop. Always go to IDLE.
- `read` is 1 exactly when the state is BURST or SINGLE.
- **rd_count:** increments by 1 on each downstream transfer and wraps modulo 2^CNT_WIDTH.
- **Ordering:** words are delivered in FIFO order. No word is dropped or duplicated.

## Timing
- **Reset values:** `read=0`, `m_valid=0`, `m_data=0`, `rd_count=0`, `occ=0`, state IDLE.
  - Reset asserted mid-burst clears everything immediately; an in-flight `dout` is discarded.
  - The first read after reset release comes no earlier than the edge after the first edge where `go` is sampled high.
- **Latency:**
  - `empty` sampled low at edge N gives `read=1` after edge N.
  - The FIFO pops at edge N+1.
  - The word is captured and `m_valid=1` after edge N+2, i.e. 2 cycles.
- **Throughput:**
  - With `ale=0` and `m_ready=1`, one word per cycle in steady state (`occ=1`, `read=1`).
  - When `ale=1`, at most one read every 3 cycles (SINGLE, GAP, IDLE).
- **m_data** changes only at a pop, or at a push into an empty buffer.
- **Backpressure:** with `m_ready=0`, `read` drops once `occ_next + read` would exceed 2. `occ` then saturates at exactly 3.
- **enable:** deasserting `enable` in BURST goes to GAP at the next edge; the last issued word still lands.
- **Simultaneous events:** push and pop at the same edge is legal at any `occ`, including `occ=3` (pop then push), with no data loss.

## Test plan
- **Burst:** FIFO preloaded with 8 words 0x01..0x08, `ale` low until 2 remain, `m_ready=1`.
  - `read` is high contiguously in BURST, followed by SINGLE reads.
  - `m_data` sequence is 0x01..0x08.
  - `rd_count=8`; `read` is never sampled high while `empty=1`.
- **Single word:** one word 0xA5 (`empty=0`, `ale=1`).
  - One `read` pulse, then GAP.
  - `m_valid` rises 2 cycles after `empty` falls, with `m_data=0xA5`.
  - No second read.
- **Backpressure:** `m_ready=0` with 6 words available.
  - Exactly 3 reads are issued, `occ=3`, `read` stays 0.
  - Raising `m_ready` delivers all 6 words in order.
- **Enable:** `enable` dropped mid-burst.
  - `read` falls after the next edge.
  - Exactly one more word lands, and no reads occur until `enable=1`.
- **Reset mid-burst:** async `reset` low mid-burst.
  - `read`, `m_valid`, `rd_count`, `occ` go to 0 immediately.
  - After release with FIFO non-empty, the first read appears one cycle after `go`.
- **Counter wrap:** `CNT_WIDTH=4`, deliver 17 words → `rd_count=1`.
